// File: rtl/proc_param_pkg.sv
// rtl/proc_param_pkg.sv - opcodes, control states and ALU operations for proc_param
package proc_param_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_t;

  // Opcodes that are not ALU ops fall back to ADD; the ALU result is only
  // captured during T2 of an ALU instruction, so the fallback is never used.
  function automatic alu_op_t alu_op_of(input logic [2:0] opcode);
    case (opcode)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_XOR:  return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/proc_alu.sv
// rtl/proc_alu.sv - combinational W-bit ALU with zero detect
module proc_alu
  import proc_param_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_op_t      op,
  output logic [W-1:0] result,
  output logic         zero
);

  // Modulo-2^W arithmetic; subtraction is a + ~b + 1 so no borrow is kept.
  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a + ~b + W'(1);
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/proc_param.sv
// rtl/proc_param.sv - parametrised multicycle datapath processor with Run/Done sequencing
module proc_param
  import proc_param_pkg::*;
#(
  parameter int W    = 9,
  parameter int NREG = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Run,
  input  logic [W-1:0] DIN,
  output logic         Done,
  output logic [W-1:0] BusWires,
  output logic         Zflag
);

  localparam int RW = $clog2(NREG);
  localparam int IW = 3 + 2 * RW;

  state_t state, next_state;

  logic [IW-1:0] ir;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  g_reg;
  logic [W-1:0]  regs [NREG];

  logic [2:0]    opcode;
  logic [RW-1:0] ir_x;
  logic [RW-1:0] ir_y;

  logic          ir_we;
  logic          rx_we;
  logic          a_we;
  logic          g_we;
  logic          sel_g;
  logic          sel_din;
  logic          rd_en;
  logic [RW-1:0] rd_idx;
  logic [NREG-1:0] sel_r;

  alu_op_t       alu_op;
  logic [W-1:0]  alu_result;
  logic          alu_zero;

  assign opcode = ir[IW-1:IW-3];
  assign ir_x   = ir[2*RW-1:RW];
  assign ir_y   = ir[RW-1:0];
  assign alu_op = alu_op_of(opcode);

  // Control state register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= T0;
    else         state <= next_state;
  end

  // Next-state, write enables and bus source selection for each timestep.
  always_comb begin
    next_state = state;
    Done       = 1'b0;
    ir_we      = 1'b0;
    rx_we      = 1'b0;
    a_we       = 1'b0;
    g_we       = 1'b0;
    sel_g      = 1'b0;
    rd_en      = 1'b0;
    rd_idx     = ir_y;
    unique case (state)
      T0: begin
        if (Run) begin
          ir_we      = 1'b1;
          next_state = T1;
        end
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            rd_en      = 1'b1;
            rx_we      = 1'b1;
            Done       = 1'b1;
            next_state = T0;
          end
          OP_MVI: begin
            rx_we      = 1'b1;
            Done       = 1'b1;
            next_state = T0;
          end
          OP_MVNZ: begin
            rd_en      = 1'b1;
            rx_we      = ~Zflag;
            Done       = 1'b1;
            next_state = T0;
          end
          OP_NOP: begin
            Done       = 1'b1;
            next_state = T0;
          end
          default: begin
            rd_en      = 1'b1;
            rd_idx     = ir_x;
            a_we       = 1'b1;
            next_state = T2;
          end
        endcase
      end
      T2: begin
        rd_en      = 1'b1;
        g_we       = 1'b1;
        next_state = T3;
      end
      T3: begin
        sel_g      = 1'b1;
        rx_we      = 1'b1;
        Done       = 1'b1;
        next_state = T0;
      end
    endcase
  end

  // One-hot register read select; DIN drives the bus whenever nothing else does.
  always_comb begin
    sel_r   = rd_en ? (NREG'(1) << rd_idx) : '0;
    sel_din = ~(sel_g | rd_en);
  end

  // AND-OR bus multiplexer over the one-hot selects.
  always_comb begin
    BusWires = (DIN & {W{sel_din}}) | (g_reg & {W{sel_g}});
    for (int i = 0; i < NREG; i++) begin
      BusWires = BusWires | (regs[i] & {W{sel_r[i]}});
    end
  end

  // Instruction register captures the low IW bits of DIN at fetch.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)    ir <= '0;
    else if (ir_we) ir <= DIN[IW-1:0];
  end

  // General registers; every RX write takes the bus value of that cycle.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (rx_we) begin
      regs[ir_x] <= BusWires;
    end
  end

  // ALU operand, result and zero flag; the flag moves only with G.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      a_reg <= '0;
      g_reg <= '0;
      Zflag <= 1'b0;
    end else begin
      if (a_we) a_reg <= BusWires;
      if (g_we) begin
        g_reg <= alu_result;
        Zflag <= alu_zero;
      end
    end
  end

  proc_alu #(.W(W)) u_alu (
    .a      (a_reg),
    .b      (BusWires),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

endmodule
